// File: rtl/neuron_pkg.sv
// neuron_pkg: shared types, widths and arithmetic helpers for the LIF neuron and STDP blocks.
package neuron_pkg;
   localparam int MEM_W = 8;

   typedef enum logic {ST_INTEGRATE, ST_REFRACTORY} state_t;

   function automatic logic [MEM_W-1:0] sat_add(input logic [MEM_W-1:0] a, input logic [MEM_W-1:0] b);
      logic [MEM_W:0] s;
      s = {1'b0, a} + {1'b0, b};
      return s[MEM_W] ? {MEM_W{1'b1}} : s[MEM_W-1:0];
   endfunction
endpackage

// File: rtl/spike_edge_detect.sv
// spike_edge_detect: one-cycle pulse on a rising edge of din; the history register tracks din even while ena is low.
module spike_edge_detect (
   input  logic clk,
   input  logic rst_n,
   input  logic ena,
   input  logic din,
   output logic pulse
);
   logic q;

   always_ff @(posedge clk or negedge rst_n)
      if (!rst_n) q <= 1'b0;
      else        q <= din;

   assign pulse = din & ~q & ena;
endmodule

// File: rtl/lif_neuron.sv
// lif_neuron: leaky integrate-and-fire neuron with shift leak, saturating integration,
// refractory period and a saturating fire counter.
module lif_neuron
   import neuron_pkg::*;
#(
   parameter logic [MEM_W-1:0] THRESHOLD       = 8'd200,
   parameter logic [MEM_W-1:0] RESET_POTENTIAL = 8'd0,
   parameter int unsigned      LEAK_SHIFT      = 3,
   parameter int unsigned      LEAK_PERIOD     = 16,
   parameter int unsigned      REFRACTORY      = 8
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             ena,
   input  logic             pre_spike,
   input  logic [MEM_W-1:0] weight,
   output logic             post_spike,
   output logic [MEM_W-1:0] membrane,
   output logic             refractory,
   output logic [MEM_W-1:0] spike_count
);
   localparam int LW = (LEAK_PERIOD > 1) ? $clog2(LEAK_PERIOD) : 1;

   state_t           state;
   logic [LW-1:0]    leak_cnt;
   logic [7:0]       refr_cnt;
   logic             pre_event;
   logic             leak_tick;
   logic [MEM_W-1:0] leak;
   logic [MEM_W-1:0] sum;
   logic             fire;

   spike_edge_detect u_edge (
      .clk   (clk),
      .rst_n (rst_n),
      .ena   (ena),
      .din   (pre_spike),
      .pulse (pre_event)
   );

   // Leak comes off the old membrane before the weight is added; the subtraction cannot underflow.
   assign leak_tick  = (leak_cnt == LW'(LEAK_PERIOD - 1));
   assign leak       = leak_tick ? (membrane >> LEAK_SHIFT) : '0;
   assign sum        = sat_add(membrane - leak, pre_event ? weight : '0);
   assign fire       = (sum >= THRESHOLD);
   assign refractory = (state == ST_REFRACTORY);

   always_ff @(posedge clk or negedge rst_n)
      if (!rst_n) begin
         state       <= ST_INTEGRATE;
         membrane    <= RESET_POTENTIAL;
         post_spike  <= 1'b0;
         spike_count <= '0;
         leak_cnt    <= '0;
         refr_cnt    <= '0;
      end else begin
         post_spike <= 1'b0;
         if (ena) begin
            leak_cnt <= leak_tick ? '0 : leak_cnt + 1'b1;
            if (state == ST_INTEGRATE) begin
               if (fire) begin
                  post_spike  <= 1'b1;
                  membrane    <= RESET_POTENTIAL;
                  spike_count <= sat_add(spike_count, 8'd1);
                  if (REFRACTORY > 0) begin
                     state    <= ST_REFRACTORY;
                     refr_cnt <= 8'(REFRACTORY - 1);
                  end
               end else begin
                  membrane <= sum;
               end
            end else begin
               refr_cnt <= refr_cnt - 1'b1;
               if (refr_cnt == '0) state <= ST_INTEGRATE;
            end
         end
      end
endmodule

// File: tb/tb_lif_neuron.sv
// tb_lif_neuron: scoreboard bench; a cycle model pushes expected outputs as stimulus is applied,
// popped and compared one clock later, plus directed value checks for the key scenarios.
module tb_lif_neuron;
   typedef struct {
      logic [7:0] mem;
      logic       post;
      logic       refr;
      logic [7:0] cnt;
   } exp_t;

   logic       clk = 1'b0;
   logic       rst_n, ena, pre_spike, s_pre;
   logic [7:0] weight, s_w;
   logic       post_spike, refractory, s_post, s_refr;
   logic [7:0] membrane, spike_count, s_mem, s_cnt;

   int checks = 0, errors = 0;
   exp_t q[$];
   int m_mem, m_post, m_refr, m_rc, m_lc, m_cnt, m_pq;

   lif_neuron dut (
      .clk(clk), .rst_n(rst_n), .ena(ena), .pre_spike(pre_spike), .weight(weight),
      .post_spike(post_spike), .membrane(membrane), .refractory(refractory), .spike_count(spike_count)
   );

   lif_neuron #(.THRESHOLD(8'd255)) dut_sat (
      .clk(clk), .rst_n(rst_n), .ena(ena), .pre_spike(s_pre), .weight(s_w),
      .post_spike(s_post), .membrane(s_mem), .refractory(s_refr), .spike_count(s_cnt)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
      end
   endtask

   task automatic model_reset();
      m_mem = 0; m_post = 0; m_refr = 0; m_rc = 0; m_lc = 0; m_cnt = 0; m_pq = 0;
   endtask

   task automatic step();
      exp_t e;
      int ev, tick, lk, s;
      ev = pre_spike && !m_pq && ena;
      m_pq = pre_spike;
      m_post = 0;
      if (ena) begin
         tick = (m_lc == 15);
         m_lc = tick ? 0 : m_lc + 1;
         if (!m_refr) begin
            lk = tick ? m_mem / 8 : 0;
            s = m_mem - lk + (ev ? int'(weight) : 0);
            if (s > 255) s = 255;
            if (s >= 200) begin
               m_post = 1; m_mem = 0; m_refr = 1; m_rc = 7;
               if (m_cnt < 255) m_cnt++;
            end else m_mem = s;
         end else if (m_rc == 0) m_refr = 0;
         else m_rc--;
      end
      e.mem = 8'(m_mem); e.post = 1'(m_post); e.refr = 1'(m_refr); e.cnt = 8'(m_cnt);
      q.push_back(e);
      @(posedge clk); #1;
      e = q.pop_front();
      chk("sb_membrane", membrane, e.mem);
      chk("sb_post", post_spike, e.post);
      chk("sb_refractory", refractory, e.refr);
      chk("sb_count", spike_count, e.cnt);
   endtask

   task automatic align();
      for (int i = 0; i < 20 && m_lc != 0; i++) step();
   endtask

   task automatic mid_reset();
      #3 rst_n = 1'b0;
      #1;
      chk("arst_membrane", membrane, 0);
      chk("arst_post", post_spike, 0);
      chk("arst_refractory", refractory, 0);
      chk("arst_count", spike_count, 0);
      model_reset();
      @(posedge clk); #2 rst_n = 1'b1;
   endtask

   initial begin
      int n, t1, t2, prev;
      rst_n = 1'b0; ena = 1'b1; pre_spike = 1'b0; weight = 8'd0; s_pre = 1'b0; s_w = 8'd0;
      model_reset();
      repeat (2) @(posedge clk);
      #1;
      chk("rst_membrane", membrane, 0);
      chk("rst_post", post_spike, 0);
      chk("rst_refractory", refractory, 0);
      chk("rst_count", spike_count, 0);
      rst_n = 1'b1;

      // integrate twice and fire, then refractory with a masked pulse
      align();
      weight = 8'd100; pre_spike = 1'b1; step(); pre_spike = 1'b0;
      chk("int1_membrane", membrane, 100);
      step(); step();
      pre_spike = 1'b1; step(); pre_spike = 1'b0;
      chk("fire_post", post_spike, 1);
      chk("fire_membrane", membrane, 0);
      chk("fire_count", spike_count, 1);
      n = int'(refractory);
      for (int i = 0; i < 12; i++) begin
         if (i == 2) begin pre_spike = 1'b1; weight = 8'd255; end
         if (i == 3) pre_spike = 1'b0;
         step();
         n += int'(refractory);
      end
      chk("refr_len", n, 8);
      chk("refr_exit_membrane", membrane, 0);
      chk("refr_no_second", spike_count, 1);

      // held input integrates once, then ena=0 loses edges
      align();
      weight = 8'd150; pre_spike = 1'b1;
      repeat (10) step();
      pre_spike = 1'b0; step();
      chk("held_membrane", membrane, 150);
      chk("held_count", spike_count, 1);
      ena = 1'b0; pre_spike = 1'b1; step(); step();
      ena = 1'b1; step(); pre_spike = 1'b0; step();
      chk("ena_membrane", membrane, 150);

      mid_reset();

      // leak from 160: 140 then 123, 16 cycles apart
      weight = 8'd160; pre_spike = 1'b1; step(); pre_spike = 1'b0;
      chk("leak_load", membrane, 160);
      t1 = -1; t2 = -1; prev = int'(membrane);
      for (int t = 1; t <= 40 && t2 < 0; t++) begin
         step();
         if (int'(membrane) != prev) begin
            if (t1 < 0) begin t1 = t; chk("leak1", membrane, 140); end
            else begin t2 = t; chk("leak2", membrane, 123); end
            prev = int'(membrane);
         end
      end
      chk("leak_gap", t2 - t1, 16);

      // reset in the middle of refractory
      weight = 8'd255; pre_spike = 1'b1; step(); pre_spike = 1'b0;
      chk("rf_post", post_spike, 1);
      step(); step();
      chk("rf_active", refractory, 1);
      mid_reset();

      // saturating fire counter
      weight = 8'd255;
      for (int k = 0; k < 300; k++) begin
         pre_spike = 1'b1; step(); pre_spike = 1'b0;
         for (int i = 0; i < 12 && refractory; i++) step();
      end
      chk("count_sat", spike_count, 255);

      // saturated sum reaching THRESHOLD=255
      align();
      s_w = 8'd200; s_pre = 1'b1; step(); s_pre = 1'b0;
      chk("s_int", s_mem, 200);
      chk("s_nofire", s_cnt, 0);
      step();
      s_w = 8'd100; s_pre = 1'b1; step(); s_pre = 1'b0;
      chk("s_post", s_post, 1);
      chk("s_membrane", s_mem, 0);
      chk("s_count", s_cnt, 1);
      chk("s_refractory", s_refr, 1);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule
